regfile_param: RTL and testbench

- Parametrised successor to the downsampling processor's fixed 16x19-bit register file.
- Provides one write port (C), two asynchronous read ports (A, B) and a per-register synchronous clear.
- Dedicated address register (AR) and data register (DR) drive the data-memory interface.
- Adds two behaviours the fixed file lacks: a handshaked memory-load path with a busy state machine, and auto-increment of any register for pixel-address stepping.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_ld_fsm.sv | 55 +++++
 rtl/regfile_param.sv | 87 ++++++++
 tb/tb_regfile_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: memory-operation
// encodings, load-FSM state constants and default geometry constants that
// the ALU and controller reuse.
package regfile_pkg;

   // Default geometry of the downsampling processor's register file.
   localparam int DEF_DATA_W   = 19;
   localparam int DEF_MEM_W    = 8;
   localparam int DEF_NREGS    = 16;
   localparam int DEF_SEL_W    = 4;
   localparam int DEF_AR_IDX   = 1;
   localparam int DEF_DR_IDX   = 2;
   localparam int DEF_INC_STEP = 1;

   // Data-memory operation encodings; 2'b11 is reserved and ignored.
   localparam logic [1:0] MEMOP_NONE  = 2'b00;
   localparam logic [1:0] MEMOP_LOAD  = 2'b01;
   localparam logic [1:0] MEMOP_STORE = 2'b10;

   // Load-FSM state encoding, kept as plain constants for legacy tools.
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_WAIT_LD = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_ld_fsm.sv
// Memory load/store controller for the register file. Owns the IDLE/WAIT_LD
// state, the busy flag, the one-cycle DR capture strobe and the store strobe.
module regfile_ld_fsm
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mem_op,
   input  logic       mem_rdy,
   output logic       busy,
   output logic       ld_cap,
   output logic       dm_we
);

   state_t state;
   state_t state_nxt;

   // Next-state, capture and store decode from the current state and request.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_nxt = state;
      ld_cap    = 1'b0;
      dm_we     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_op == MEMOP_LOAD) begin
               if (mem_rdy) ld_cap    = 1'b1;
               else         state_nxt = ST_WAIT_LD;
            end else if (mem_op == MEMOP_STORE) begin
               dm_we = 1'b1;
            end
         end
         ST_WAIT_LD: begin
            // New requests are ignored while a load is outstanding.
            if (mem_rdy) begin
               ld_cap    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset abandons any outstanding load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   assign busy = (state == ST_WAIT_LD);

endmodule : regfile_ld_fsm

// File: rtl/regfile_param.sv
// Parametrised register file: one write port (C), two combinational read
// ports (A, B), per-register clear, auto-increment, and AR/DR registers
// feeding the data-memory interface with a handshaked load path.
// Optional build macro: REGFILE_BYPASS_EN forwards a same-cycle C write to
// the A/B read ports (the memory interface is never bypassed).
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MEM_W    = DEF_MEM_W,
   parameter int NREGS    = DEF_NREGS,
   parameter int SEL_W    = DEF_SEL_W,
   parameter int AR_IDX   = DEF_AR_IDX,
   parameter int DR_IDX   = DEF_DR_IDX,
   parameter int INC_STEP = DEF_INC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  clr_sel,
   input  logic              c_we,
   input  logic [SEL_W-1:0]  c_sel,
   input  logic [DATA_W-1:0] c_in,
   input  logic [SEL_W-1:0]  a_sel,
   input  logic [SEL_W-1:0]  b_sel,
   input  logic [SEL_W-1:0]  inc_sel,
   input  logic [1:0]        mem_op,
   input  logic              mem_rdy,
   input  logic [MEM_W-1:0]  mem_data,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] dm_addr,
   output logic [MEM_W-1:0]  dm_data,
   output logic              dm_we,
   output logic              busy
);

   logic [DATA_W-1:0] regs [NREGS];
   logic              ld_cap;
   logic [DATA_W-1:0] ld_value;

   regfile_ld_fsm u_ld_fsm (
      .clk     (clk),
      .rst     (rst),
      .mem_op  (mem_op),
      .mem_rdy (mem_rdy),
      .busy    (busy),
      .ld_cap  (ld_cap),
      .dm_we   (dm_we)
   );

   assign ld_value = DATA_W'(mem_data);

   // Register array: each register picks its highest-priority update source.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is small and architecturally visible after reset,
         // so every entry is cleared; this forces flops rather than RAM.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         regs[0] <= '0;
         for (int i = 1; i < NREGS; i++) begin
            if (clr_sel == SEL_W'(i))
               regs[i] <= '0;
            else if (ld_cap && (i == DR_IDX))
               regs[i] <= ld_value;
            else if (c_we && (c_sel == SEL_W'(i)))
               regs[i] <= c_in;
            else if (inc_sel == SEL_W'(i))
               regs[i] <= regs[i] + DATA_W'(INC_STEP);
         end
      end
   end

   // Read ports, optionally forwarding the C-port write in the same cycle.
   always_comb begin
      a_out = regs[a_sel];
      b_out = regs[b_sel];
`ifdef REGFILE_BYPASS_EN
      if (c_we && (c_sel != '0) && (c_sel == a_sel)) a_out = c_in;
      if (c_we && (c_sel != '0) && (c_sel == b_sel)) b_out = c_in;
`endif
   end

   assign dm_addr = regs[AR_IDX];
   assign dm_data = regs[DR_IDX][MEM_W-1:0];

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios followed by
// randomised traffic, compared against a behavioural model of the register
// file built from the update-priority rules.
module tb_regfile_param;

   localparam int DW   = 19;
   localparam int MW   = 8;
   localparam int NR   = 16;
   localparam int SW   = 4;
   localparam int AR   = 1;
   localparam int DR   = 2;
   localparam int STEP = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] clr_sel, c_sel, a_sel, b_sel, inc_sel;
   logic          c_we;
   logic [DW-1:0] c_in;
   logic [1:0]    mem_op;
   logic          mem_rdy;
   logic [MW-1:0] mem_data;
   logic [DW-1:0] a_out, b_out, dm_addr;
   logic [MW-1:0] dm_data;
   logic          dm_we, busy;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   logic [DW-1:0] m_r [NR];
   bit            m_busy;

   regfile_param #(
      .DATA_W(DW), .MEM_W(MW), .NREGS(NR), .SEL_W(SW),
      .AR_IDX(AR), .DR_IDX(DR), .INC_STEP(STEP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr_sel  (clr_sel),
      .c_we     (c_we),
      .c_sel    (c_sel),
      .c_in     (c_in),
      .a_sel    (a_sel),
      .b_sel    (b_sel),
      .inc_sel  (inc_sel),
      .mem_op   (mem_op),
      .mem_rdy  (mem_rdy),
      .mem_data (mem_data),
      .a_out    (a_out),
      .b_out    (b_out),
      .dm_addr  (dm_addr),
      .dm_data  (dm_data),
      .dm_we    (dm_we),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected read-port value for the current inputs and model contents.
   function automatic logic [DW-1:0] exp_port(input logic [SW-1:0] sel);
`ifdef REGFILE_BYPASS_EN
      if (c_we && sel != 0 && c_sel == sel) return c_in;
`endif
      return (sel == 0) ? '0 : m_r[sel];
   endfunction

   // Apply one clock edge to the model: lower-priority sources are applied
   // first and overwritten by higher-priority ones.
   task automatic model_edge();
      logic [DW-1:0] nxt [NR];
      bit            cap;
      if (rst) begin
         foreach (m_r[i]) m_r[i] = '0;
         m_busy = 0;
         return;
      end
      cap = mem_rdy && (m_busy || mem_op == 2'b01);
      nxt = m_r;
      if (inc_sel != 0)        nxt[inc_sel] = m_r[inc_sel] + DW'(STEP);
      if (c_we && c_sel != 0)  nxt[c_sel]   = c_in;
      if (cap)                 nxt[DR]      = {{(DW-MW){1'b0}}, mem_data};
      if (clr_sel != 0)        nxt[clr_sel] = '0;
      m_busy = m_busy ? !mem_rdy : (mem_op == 2'b01 && !mem_rdy);
      m_r = nxt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic quiet();
      clr_sel = 0; c_we = 0; c_sel = 0; c_in = 0; inc_sel = 0;
      mem_op = 2'b00; mem_rdy = 0; mem_data = 0;
   endtask

   task automatic check_all(input string tag);
      #1;
      check({tag, ".a_out"},   a_out,   exp_port(a_sel));
      check({tag, ".b_out"},   b_out,   exp_port(b_sel));
      check({tag, ".dm_addr"}, dm_addr, m_r[AR]);
      check({tag, ".dm_data"}, dm_data, m_r[DR][MW-1:0]);
      check({tag, ".dm_we"},   dm_we,   (!m_busy && mem_op == 2'b10));
      check({tag, ".busy"},    busy,    m_busy);
   endtask

   task automatic write_reg(input int idx, input logic [DW-1:0] val);
      quiet();
      c_we = 1; c_sel = SW'(idx); c_in = val;
      step();
      quiet();
   endtask

   initial begin
      quiet();
      a_sel = 0; b_sel = 0;
      rst = 1;
      foreach (m_r[i]) m_r[i] = 'x;
      m_busy = 1;

      // Reset, clear and R0.
      step(); step();
      rst = 0;
      for (int i = 0; i < NR; i++) begin
         a_sel = SW'(i); b_sel = SW'(NR - 1 - i);
         #1;
         check("rst_a", a_out, 0);
         check("rst_b", b_out, 0);
      end
      check("rst_busy", busy, 0);
      check("rst_dm_we", dm_we, 0);
      clr_sel = 1; step(); quiet();
      c_we = 1; c_sel = 0; c_in = 123; a_sel = 0;
      check_all("r0_wr");
      step(); quiet();
      #1 check("r0_reads_0", a_out, 0);
      c_we = 1; c_sel = 3; c_in = 10; a_sel = 3;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("r3_bypass", a_out, 10);
`else
      check("r3_pre_edge", a_out, 0);
`endif
      step(); quiet();
      #1 check("r3_written", a_out, 10);

      // Simultaneous events on R5.
      write_reg(5, 7);
      c_we = 1; c_sel = 5; c_in = 20; inc_sel = 5;
      step(); quiet();
      a_sel = 5;
      #1 check("r5_write_beats_inc", a_out, 20);
      clr_sel = 5; c_we = 1; c_sel = 5; c_in = 99;
      step(); quiet();
      #1 check("r5_clear_beats_write", a_out, 0);

      // Increment wrap of AR.
      write_reg(AR, 19'h7FFFF);
      #1 check("ar_preload", dm_addr, 19'h7FFFF);
      inc_sel = AR;
      step(); quiet();
      #1 check("ar_wrap", dm_addr, 0);

      // Delayed load, with a store attempt while busy.
      mem_op = 2'b01; mem_rdy = 0;
      step(); quiet();
      check_all("ld_wait1");
      check("ld_busy1", busy, 1);
      mem_op = 2'b10;
      #1 check("ld_no_store_busy", dm_we, 0);
      step(); quiet();
      check("ld_busy2", busy, 1);
      step();
      check("ld_busy3", busy, 1);
      mem_rdy = 1; mem_data = 8'hAB;
      check_all("ld_cap_cycle");
      check("ld_busy_cap", busy, 1);
      step(); quiet();
      a_sel = DR;
      #1;
      check("ld_busy_done", busy, 0);
      check("ld_dm_data", dm_data, 8'hAB);
      check("ld_dr", a_out, 19'h000AB);

      // Store strobe.
      write_reg(AR, 19'h00100);
      write_reg(DR, 19'h0003C);
      mem_op = 2'b10;
      #1;
      check("st_we", dm_we, 1);
      check("st_addr", dm_addr, 19'h00100);
      check("st_data", dm_data, 8'h3C);
      step(); quiet();
      #1 check("st_we_drop", dm_we, 0);

      // Reset during an outstanding load.
      mem_op = 2'b01;
      step(); quiet();
      #1 check("rl_busy", busy, 1);
      rst = 1; step(); rst = 0;
      #1 check("rl_busy_cleared", busy, 0);
      mem_rdy = 1; mem_data = 8'hFF;
      step(); quiet();
      a_sel = DR;
      #1;
      check("rl_dm_data", dm_data, 0);
      check("rl_dr", a_out, 0);
      check("rl_busy_after", busy, 0);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         clr_sel  = ($urandom_range(0, 3) == 0) ? SW'($urandom) : '0;
         c_we     = $urandom_range(0, 1) == 1;
         c_sel    = SW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
         c_in     = DW'($urandom);
         inc_sel  = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 3)) : '0;
         a_sel    = SW'($urandom);
         b_sel    = SW'($urandom_range(0, 3));
         mem_op   = 2'($urandom);
         mem_rdy  = ($urandom_range(0, 2) == 0);
         mem_data = MW'($urandom);
         check_all("rand");
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_param
